// File: rtl/args_sync_filt.sv
// Multi-channel N-stage synchronizer with per-channel stability filter and
// registered rise/fall/change pulses for slow asynchronous inputs.
module args_sync_filt #(
    parameter int unsigned  W    = 8,
    parameter int unsigned  N    = 2,
    parameter logic [W-1:0] INIT = '0,
    parameter int unsigned  FILT = 4
) (
    input  logic         c,
    input  logic         r,
    input  logic [W-1:0] i,
    output logic [W-1:0] o,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall,
    output logic         chg
);

    localparam int unsigned CW = $clog2(FILT + 1);

    (* ASYNC_REG = "TRUE", shreg_extract = "no" *) logic [W-1:0] sync_q [N];

    logic [W-1:0]  sy_c;
    logic [W-1:0]  upd_c;
    logic [W-1:0]  o_q, o_d;
    logic [W-1:0]  rise_q, rise_d;
    logic [W-1:0]  fall_q, fall_d;
    logic          chg_q, chg_d;
    logic [CW-1:0] cnt_q [W];
    logic [CW-1:0] cnt_d [W];

    // Plain flop chain, nothing between stages.
    always_ff @(posedge c) begin
        if (r) begin
            for (int j = 0; j < N; j++) sync_q[j] <= INIT;
        end else begin
            sync_q[0] <= i;
            for (int j = 1; j < N; j++) sync_q[j] <= sync_q[j-1];
        end
    end

    assign sy_c = sync_q[N-1];

    // Output follows sy only after FILT consecutive mismatching cycles.
    always_comb begin
        o_d   = o_q;
        upd_c = '0;
        for (int k = 0; k < W; k++) begin
            cnt_d[k] = cnt_q[k];
            if (sy_c[k] == o_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == CW'(FILT - 1)) begin
                upd_c[k] = 1'b1;
                o_d[k]   = sy_c[k];
                cnt_d[k] = '0;
            end else begin
                cnt_d[k] = cnt_q[k] + CW'(1);
            end
        end
        rise_d = upd_c & sy_c;
        fall_d = upd_c & ~sy_c;
        chg_d  = |upd_c;
    end

    always_ff @(posedge c) begin
        if (r) begin
            o_q    <= INIT;
            rise_q <= '0;
            fall_q <= '0;
            chg_q  <= 1'b0;
            for (int k = 0; k < W; k++) cnt_q[k] <= '0;
        end else begin
            o_q    <= o_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            chg_q  <= chg_d;
            for (int k = 0; k < W; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    assign o    = o_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign chg  = chg_q;

endmodule

// File: tb/tb_args_sync_filt.sv
// Bench for args_sync_filt: step table, corner sequences, INIT=A5 instance,
// N x FILT sweep, and randomized traffic against a window-based reference model.
module tb_args_sync_filt;

    localparam int MN = 2;
    localparam int MF = 4;

    logic c = 1'b0;
    always #5 c = ~c;

    int n_run  = 0;
    int n_fail = 0;

    logic       r_a, r_b, r_s;
    logic [7:0] i_a, i_b;
    logic       i_s;
    logic [7:0] o_a, rise_a, fall_a, o_b, rise_b, fall_b;
    logic       chg_a, chg_b;
    logic [8:0] sw_o, sw_rise, sw_fall, sw_chg;

    args_sync_filt #(.W(8), .N(2), .INIT(8'h00), .FILT(4)) dut_a (
        .c(c), .r(r_a), .i(i_a), .o(o_a), .rise(rise_a), .fall(fall_a), .chg(chg_a));

    args_sync_filt #(.W(8), .N(2), .INIT(8'hA5), .FILT(4)) dut_b (
        .c(c), .r(r_b), .i(i_b), .o(o_b), .rise(rise_b), .fall(fall_b), .chg(chg_b));

    for (genvar a = 0; a < 3; a++) begin : g_n
        for (genvar b = 0; b < 3; b++) begin : g_f
            localparam int unsigned PN = unsigned'(a) + 2;
            localparam int unsigned PF = (b == 0) ? 1 : ((b == 1) ? 4 : 16);
            args_sync_filt #(.W(1), .N(PN), .INIT(1'b0), .FILT(PF)) u_sw (
                .c(c), .r(r_s), .i(i_s), .o(sw_o[a*3+b]), .rise(sw_rise[a*3+b]),
                .fall(sw_fall[a*3+b]), .chg(sw_chg[a*3+b]));
        end
    end

    // Reference: sampled-input history feeds sy; o flips when the last MF sy
    // values all disagree with it.
    logic [7:0] hist [$];
    logic [7:0] syh  [$];
    logic [7:0] mo, mrise, mfall;
    logic       mchg;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic [7:0] iv, input logic rv);
        logic [7:0] sy, e;
        bit all_diff;
        if (rv) begin
            hist.delete();
            for (int j = 0; j < MN; j++) hist.push_back(8'h00);
            syh.delete();
            mo = '0; mrise = '0; mfall = '0; mchg = 1'b0;
        end else begin
            sy = hist[hist.size() - MN];
            hist.push_back(iv);
            if (hist.size() > 16) void'(hist.pop_front());
            syh.push_back(sy);
            if (syh.size() > 16) void'(syh.pop_front());
            mrise = '0; mfall = '0;
            for (int k = 0; k < 8; k++) begin
                if (syh.size() >= MF) begin
                    all_diff = 1'b1;
                    for (int m = 0; m < MF; m++) begin
                        e = syh[syh.size() - 1 - m];
                        if (e[k] == mo[k]) all_diff = 1'b0;
                    end
                    if (all_diff) begin
                        mo[k] = sy[k];
                        if (sy[k]) mrise[k] = 1'b1;
                        else       mfall[k] = 1'b1;
                    end
                end
            end
            mchg = |(mrise | mfall);
        end
    endtask

    task automatic tick(input logic [7:0] iv, input logic rv);
        i_a = iv;
        r_a = rv;
        @(posedge c);
        #1;
        model_step(iv, rv);
        chk("model", 32'({o_a, rise_a, fall_a, chg_a}), 32'({mo, mrise, mfall, mchg}));
    endtask

    typedef struct {
        logic       r;
        logic [7:0] i;
        logic [7:0] o;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       chg;
    } vec_t;

    vec_t tbl [15];

    initial begin
        int         seen, hi_cnt, ri, fi, idx, chg_cnt;
        logic [7:0] pat, cap_r, cap_f, rv_i;
        int         first_r [9];
        logic       smp [64];
        int         pn, pf;

        r_a = 1'b1; i_a = '0;
        r_b = 1'b1; i_b = 8'hA5;
        r_s = 1'b1; i_s = 1'b0;

        tbl[0] = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        for (int v = 1; v <= 5; v++) tbl[v] = '{1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[6] = '{1'b0, 8'h01, 8'h01, 8'h01, 8'h00, 1'b1};
        tbl[7] = '{1'b0, 8'h01, 8'h01, 8'h00, 8'h00, 1'b0};
        for (int v = 8; v <= 12; v++) tbl[v] = '{1'b0, 8'h00, 8'h01, 8'h00, 8'h00, 1'b0};
        tbl[13] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1};
        tbl[14] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};

        // Step on channel 0, up then down.
        for (int v = 0; v < 15; v++) begin
            tick(tbl[v].i, tbl[v].r);
            chk($sformatf("step[%0d]", v), 32'({o_a, rise_a, fall_a, chg_a}),
                32'({tbl[v].o, tbl[v].rise, tbl[v].fall, tbl[v].chg}));
        end

        // Glitch of 3 cycles is swallowed.
        tick(8'h00, 1'b1);
        seen = 0;
        for (int t = 0; t < 3; t++) begin tick(8'h08, 1'b0); if (o_a[3] || chg_a) seen = 1; end
        for (int t = 0; t < 12; t++) begin tick(8'h00, 1'b0); if (o_a[3] || chg_a) seen = 1; end
        chk("glitch3_quiet", 32'(seen), 32'd0);

        // Pulse of 4 cycles passes with the same width.
        hi_cnt = 0; ri = -1; fi = -1; idx = 0;
        for (int t = 0; t < 16; t++) begin
            tick((t < 4) ? 8'h08 : 8'h00, 1'b0);
            idx++;
            if (o_a[3]) hi_cnt++;
            if (rise_a[3]) ri = idx;
            if (fall_a[3]) fi = idx;
        end
        chk("glitch4_len", 32'(hi_cnt), 32'd4);
        chk("glitch4_rise_at", 32'(ri), 32'd6);
        chk("glitch4_gap", 32'(fi - ri), 32'd4);

        // Interrupted run restarts the count.
        tick(8'h00, 1'b1);
        pat = 8'b1110_1111;
        ri = -1;
        for (int t = 0; t < 16; t++) begin
            tick((t < 8 && !pat[7-t]) ? 8'h00 : 8'h02, 1'b0);
            if (ri < 0 && rise_a[1]) ri = t;
        end
        chk("restart_rise_at", 32'(ri), 32'd9);

        // Reset lands one cycle before a commit.
        tick(8'h00, 1'b1);
        for (int t = 0; t < 5; t++) tick(8'h04, 1'b0);
        tick(8'h04, 1'b1);
        chk("rst_mid_clear", 32'({o_a, rise_a, fall_a, chg_a}), 32'd0);
        ri = -1;
        for (int t = 1; t <= 10; t++) begin
            tick(8'h04, 1'b0);
            if (ri < 0 && rise_a[2]) ri = t;
        end
        chk("rst_mid_rise_at", 32'(ri), 32'd6);

        // Nonzero INIT, all channels flipping together.
        r_b = 1'b1; i_b = 8'hA5;
        tick(8'h00, 1'b0);
        r_b = 1'b0;
        seen = 0;
        for (int t = 0; t < 20; t++) begin
            tick(8'h00, 1'b0);
            if ((|rise_b) || (|fall_b) || chg_b || (o_b != 8'hA5)) seen = 1;
        end
        chk("initA5_quiet", 32'(seen), 32'd0);
        i_b = 8'h5A;
        chg_cnt = 0; ri = -1; cap_r = '0; cap_f = '0;
        for (int t = 1; t <= 10; t++) begin
            tick(8'h00, 1'b0);
            if (chg_b) begin chg_cnt++; ri = t; cap_r = rise_b; cap_f = fall_b; end
        end
        chk("initA5_chg_cnt", 32'(chg_cnt), 32'd1);
        chk("initA5_chg_at", 32'(ri), 32'd6);
        chk("initA5_rise", 32'(cap_r), 32'h5A);
        chk("initA5_fall", 32'(cap_f), 32'hA5);
        chk("initA5_o", 32'(o_b), 32'h5A);

        // Step latency across the parameter sweep.
        r_s = 1'b1; i_s = 1'b0;
        tick(8'h00, 1'b0);
        r_s = 1'b0; i_s = 1'b1;
        for (int k = 0; k < 9; k++) first_r[k] = -1;
        for (int t = 1; t <= 24; t++) begin
            tick(8'h00, 1'b0);
            for (int k = 0; k < 9; k++) if (first_r[k] < 0 && sw_rise[k]) first_r[k] = t;
        end
        for (int k = 0; k < 9; k++) begin
            pn = k / 3 + 2;
            pf = (k % 3 == 0) ? 1 : ((k % 3 == 1) ? 4 : 16);
            chk($sformatf("sweep_lat_n%0d_f%0d", pn, pf), 32'(first_r[k]), 32'(pn + pf));
        end

        // FILT=1 tracks the input delayed by N edges.
        r_s = 1'b1; i_s = 1'b0;
        tick(8'h00, 1'b0);
        r_s = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            i_s = 1'($urandom_range(0, 1));
            smp[t] = i_s;
            tick(8'h00, 1'b0);
            for (int a = 0; a < 3; a++) begin
                pn = a + 2;
                chk($sformatf("f1_track_n%0d", pn), 32'(sw_o[a*3]),
                    32'((t > pn) ? smp[t - pn] : 1'b0));
            end
        end

        // Random traffic against the model, with occasional resets.
        rv_i = '0;
        for (int t = 0; t < 400; t++) begin
            for (int k = 0; k < 8; k++) if ($urandom_range(0, 5) == 0) rv_i[k] = ~rv_i[k];
            tick(rv_i, ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
